// File: rtl/s2p_frame_if.sv
// Serial-in / word-out handshake bundle between the bit source, the word
// consumer (master side) and s2p_frame_ctrl (slave side).
interface s2p_frame_if #(
  parameter int WIDTH = 8
) ();
  logic             ser_bit;
  logic             ser_valid;
  logic             word_ack;
  logic [WIDTH-1:0] word_data;
  logic             word_valid;

  modport master (
    output ser_bit, ser_valid, word_ack,
    input  word_data, word_valid
  );

  modport slave (
    input  ser_bit, ser_valid, word_ack,
    output word_data, word_valid
  );
endinterface

// File: rtl/s2p_frame_ctrl.sv
// Frame controller: hunts a start bit, shifts WIDTH bits LSB first, checks
// optional even parity and holds the word until acknowledged.
module s2p_frame_ctrl #(
  parameter int WIDTH       = 8,
  parameter int PARITY_EN   = 1,
  parameter int TIMEOUT_CYC = 25_000_000
) (
  input  logic        CLOCK_50,
  input  logic        RESET_N,
  input  logic        enable,
  s2p_frame_if.slave  bus,
  output logic        parity_err,
  output logic        timeout_err,
  output logic        overrun_err,
  output logic [3:0]  bit_cnt,
  output logic [2:0]  state
);

  localparam int            TW     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [3:0]    LAST_BIT = 4'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HUNT   = 3'd1,
    SHIFT  = 3'd2,
    PARITY = 3'd3,
    HOLD   = 3'd4
  } state_t;

  state_t           state_q, state_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic [TW-1:0]    timer, timer_n;
  logic [3:0]       cnt_n;
  logic             par_n, tout_n, ovr_n;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can leave
    // one unassigned, which would otherwise infer a latch.
    state_n = state_q;
    shreg_n = shreg;
    timer_n = timer;
    cnt_n   = bit_cnt;
    par_n   = parity_err;
    tout_n  = timeout_err;
    ovr_n   = overrun_err;

    unique case (state_q)
      IDLE: if (enable) state_n = HUNT;

      HUNT: begin
        if (!enable) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (bus.ser_valid && !bus.ser_bit) begin
          state_n = SHIFT;
          cnt_n   = '0;
          par_n   = 1'b0;
          timer_n = '0;
        end
      end

      SHIFT, PARITY: begin
        if (!enable) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (bus.ser_valid) begin
          timer_n = '0;
          if (state_q == SHIFT) begin
            shreg_n = {bus.ser_bit, shreg[WIDTH-1:1]};
            cnt_n   = bit_cnt + 4'd1;
            if (bit_cnt == LAST_BIT) state_n = (PARITY_EN != 0) ? PARITY : HOLD;
          end else begin
            par_n   = ^{shreg, bus.ser_bit};
            state_n = HOLD;
          end
        end else if (timer == T_LAST) begin
          // Reaching the limit leaves the frame, so the timer can never wrap.
          tout_n  = 1'b1;
          cnt_n   = '0;
          state_n = HUNT;
        end else begin
          timer_n = timer + 1'b1;
        end
      end

      HOLD: begin
        if (bus.word_ack)       state_n = enable ? HUNT : IDLE;
        else if (bus.ser_valid) ovr_n   = 1'b1;
      end

      default: state_n = IDLE;
    endcase

    // Sticky flags are wiped on the edge that enters IDLE, not a cycle later.
    if (state_n == IDLE) begin
      tout_n = 1'b0;
      ovr_n  = 1'b0;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!RESET_N) begin
      state_q     <= IDLE;
      shreg       <= '0;
      timer       <= '0;
      bit_cnt     <= '0;
      parity_err  <= 1'b0;
      timeout_err <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      state_q     <= state_n;
      shreg       <= shreg_n;
      timer       <= timer_n;
      bit_cnt     <= cnt_n;
      parity_err  <= par_n;
      timeout_err <= tout_n;
      overrun_err <= ovr_n;
    end
  end

  assign state          = state_q;
  assign bus.word_valid = (state_q == HOLD);
  assign bus.word_data  = shreg;

endmodule

// File: tb/tb_s2p_frame_ctrl.sv
// Self-checking bench for s2p_frame_ctrl: directed frames from the datasheet
// scenarios, then random strobes/acks/enables against a frame-level model.
module tb_s2p_frame_ctrl;

  localparam int WIDTH       = 8;
  localparam int PARITY_EN   = 1;
  localparam int TIMEOUT_CYC = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       parity_err, timeout_err, overrun_err;
  logic [3:0] bit_cnt;
  logic [2:0] state;

  s2p_frame_if #(.WIDTH(WIDTH)) bus ();

  s2p_frame_ctrl #(
    .WIDTH(WIDTH), .PARITY_EN(PARITY_EN), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .CLOCK_50(clk), .RESET_N(rst_n), .enable(enable), .bus(bus),
    .parity_err(parity_err), .timeout_err(timeout_err), .overrun_err(overrun_err),
    .bit_cnt(bit_cnt), .state(state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Frame-level reference: mode uses the displayed state codes, a frame is a
  // list of received bits, and the timeout is a count of silent cycles.
  int             m_mode, m_cnt, m_gap;
  bit             m_bits[$];
  logic [WIDTH-1:0] m_word;
  bit             m_word_known;
  bit             m_par, m_tout, m_ovr;

  function automatic logic [WIDTH-1:0] pack_bits();
    logic [WIDTH-1:0] w = '0;
    foreach (m_bits[i]) w[i] = m_bits[i];
    return w;
  endfunction

  task automatic model_step();
    if (!rst_n) begin
      m_mode = 0; m_cnt = 0; m_gap = 0; m_bits.delete();
      m_word = '0; m_word_known = 1'b1;
      m_par = 1'b0; m_tout = 1'b0; m_ovr = 1'b0;
      return;
    end
    case (m_mode)
      0: if (enable) m_mode = 1;
      1: begin
        if (!enable) begin
          m_mode = 0; m_cnt = 0;
        end else if (bus.ser_valid && !bus.ser_bit) begin
          m_mode = 2; m_cnt = 0; m_gap = 0; m_par = 1'b0; m_bits.delete();
        end
      end
      2, 3: begin
        if (!enable) begin
          m_mode = 0; m_cnt = 0;
        end else if (bus.ser_valid) begin
          m_gap = 0;
          if (m_mode == 2) begin
            m_bits.push_back(bus.ser_bit);
            m_word_known = 1'b0;
            m_cnt = m_bits.size();
            if (m_bits.size() == WIDTH) begin
              if (PARITY_EN != 0) m_mode = 3;
              else begin m_mode = 4; m_word = pack_bits(); m_word_known = 1'b1; end
            end
          end else begin
            int ones = int'(bus.ser_bit);
            foreach (m_bits[i]) ones += int'(m_bits[i]);
            m_par = (ones % 2) != 0;
            m_mode = 4; m_word = pack_bits(); m_word_known = 1'b1;
          end
        end else begin
          m_gap++;
          if (m_gap >= TIMEOUT_CYC) begin
            m_tout = 1'b1; m_cnt = 0; m_mode = 1;
          end
        end
      end
      4: begin
        if (bus.word_ack)       m_mode = enable ? 1 : 0;
        else if (bus.ser_valid) m_ovr = 1'b1;
      end
      default: m_mode = 0;
    endcase
    if (m_mode == 0) begin m_tout = 1'b0; m_ovr = 1'b0; end
  endtask

  task automatic compare_all();
    check("state",       32'(state),          32'(m_mode));
    check("word_valid",  32'(bus.word_valid), 32'(m_mode == 4));
    check("bit_cnt",     32'(bit_cnt),        32'(m_cnt));
    check("parity_err",  32'(parity_err),     32'(m_par));
    check("timeout_err", 32'(timeout_err),    32'(m_tout));
    check("overrun_err", 32'(overrun_err),    32'(m_ovr));
    if (m_word_known) check("word_data", 32'(bus.word_data), 32'(m_word));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic strobe(input logic b);
    bus.ser_valid = 1'b1;
    bus.ser_bit   = b;
    cyc();
    bus.ser_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [WIDTH-1:0] w, input logic p);
    strobe(1'b0);
    for (int i = 0; i < WIDTH; i++) strobe(w[i]);
    if (PARITY_EN != 0) strobe(p);
  endtask

  task automatic ack_word();
    bus.word_ack = 1'b1;
    cyc();
    bus.word_ack = 1'b0;
  endtask

  int quiet;

  initial begin
    rst_n = 1'b0; enable = 1'b0;
    bus.ser_bit = 1'b0; bus.ser_valid = 1'b0; bus.word_ack = 1'b0;
    cyc(); cyc();
    check("rst_state", 32'(state), 32'd0);
    check("rst_word",  32'(bus.word_data), 32'd0);
    rst_n = 1'b1;

    // 1: clean 0xA5 with correct even parity
    enable = 1'b1; cyc();
    send_frame(8'hA5, 1'b0);
    check("t1_data",  32'(bus.word_data), 32'hA5);
    check("t1_valid", 32'(bus.word_valid), 32'd1);
    check("t1_perr",  32'(parity_err), 32'd0);
    check("t1_state", 32'(state), 32'd4);
    ack_word();

    // 2: wrong parity, then ack returns to HUNT
    send_frame(8'hA5, 1'b1);
    check("t2_data", 32'(bus.word_data), 32'hA5);
    check("t2_perr", 32'(parity_err), 32'd1);
    ack_word();
    check("t2_valid", 32'(bus.word_valid), 32'd0);
    check("t2_state", 32'(state), 32'd1);

    // 3: timeout exactly TIMEOUT_CYC cycles after the last strobe
    strobe(1'b0); strobe(1'b1); strobe(1'b0); strobe(1'b1);
    for (int k = 1; k <= TIMEOUT_CYC; k++) begin
      cyc();
      if (k == TIMEOUT_CYC - 1) check("t3_pre_state", 32'(state), 32'd2);
    end
    check("t3_state", 32'(state), 32'd1);
    check("t3_tout",  32'(timeout_err), 32'd1);
    check("t3_cnt",   32'(bit_cnt), 32'd0);

    // 4: overrun in HOLD, then strobe+ack together
    send_frame(8'h3C, 1'b0);
    strobe(1'b1);
    check("t4_ovr",   32'(overrun_err), 32'd1);
    check("t4_data",  32'(bus.word_data), 32'h3C);
    bus.ser_valid = 1'b1; bus.word_ack = 1'b1;
    cyc();
    bus.ser_valid = 1'b0; bus.word_ack = 1'b0;
    check("t4_state", 32'(state), 32'd1);

    // 5: enable dropped mid-frame
    enable = 1'b0; cyc();
    check("t5_idle_tout", 32'(timeout_err), 32'd0);
    check("t5_idle_ovr",  32'(overrun_err), 32'd0);
    enable = 1'b1; cyc();
    strobe(1'b0);
    for (int i = 0; i < 4; i++) strobe(1'($urandom));
    check("t5_cnt4", 32'(bit_cnt), 32'd4);
    enable = 1'b0; cyc();
    check("t5_state", 32'(state), 32'd0);
    check("t5_cnt",   32'(bit_cnt), 32'd0);
    for (int i = 0; i < 3; i++) cyc();
    check("t5_flags", 32'({parity_err, timeout_err, overrun_err}), 32'd0);

    // 6: reset mid-frame, then a clean 0x5A
    enable = 1'b1; cyc();
    strobe(1'b0); strobe(1'b1); strobe(1'b1); strobe(1'b0);
    rst_n = 1'b0; cyc(); rst_n = 1'b1;
    check("t6_state", 32'(state), 32'd0);
    check("t6_outs",  32'({bus.word_data, bus.word_valid, bit_cnt,
                           parity_err, timeout_err, overrun_err}), 32'd0);
    cyc();
    send_frame(8'h5A, 1'b0);
    check("t6_data", 32'(bus.word_data), 32'h5A);
    check("t6_perr", 32'(parity_err), 32'd0);
    ack_word();

    // Random traffic against the model
    quiet = 0;
    for (int i = 0; i < 4000; i++) begin
      rst_n  = ($urandom_range(0, 599) != 0);
      enable = enable ? ($urandom_range(0, 149) != 0) : ($urandom_range(0, 9) == 0);
      if (quiet > 0) begin
        bus.ser_valid = 1'b0;
        quiet--;
      end else begin
        bus.ser_valid = ($urandom_range(0, 99) < 40);
        if ($urandom_range(0, 149) == 0) quiet = $urandom_range(12, 22);
      end
      bus.ser_bit  = 1'($urandom);
      bus.word_ack = ($urandom_range(0, 99) < 20);
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
